seq_period_meter: RTL and testbench

Downstream monitor for the counter/LFSR sequence generator. It samples the generator's output word every enabled cycle and measures the sequence period for the active width mode: the number of enabled samples until the first captured value recurs. It also flags stuck (period 1) and runaway (no recurrence) sequences. The resulting period, done and flag outputs are the figures the team uses to compare counter and LFSR implementations in every mode.

---
 rtl/seq_period_meter.sv | 129 ++++++++++++
 tb/tb_seq_period_meter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_period_meter.sv
// Sequence period meter: arms on the first enabled sample, counts enabled samples
// until that value recurs (under the active width mask), and flags stuck/runaway sequences.
module seq_period_meter #(
   parameter int WIDTH     = 11,
   parameter int CNT_W     = 12,
   parameter int MAX_COUNT = 4095
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] seq_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period,
   output logic             stuck,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] ref_reg, ref_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       mode_q_reg;
   logic             done_reg, done_next;
   logic [CNT_W-1:0] period_reg, period_next;
   logic             stuck_reg, stuck_next;
   logic             timeout_reg, timeout_next;

   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] sample;
   logic [CNT_W-1:0] cnt_inc;
   logic             mode_chg;

   // Active width is 8+mode bits; everything above it is ignored.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign mask[gi] = (6'(gi) < (6'd8 + 6'(mode)));
   end

   assign sample   = seq_in & mask;
   assign cnt_inc  = cnt_reg + CNT_W'(1);
   assign mode_chg = (mode != mode_q_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ref_reg     <= '0;
         cnt_reg     <= '0;
         mode_q_reg  <= '0;
         done_reg    <= 1'b0;
         period_reg  <= '0;
         stuck_reg   <= 1'b0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ref_reg     <= ref_next;
         cnt_reg     <= cnt_next;
         mode_q_reg  <= mode;
         done_reg    <= done_next;
         period_reg  <= period_next;
         stuck_reg   <= stuck_next;
         timeout_reg <= timeout_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      ref_next     = ref_reg;
      cnt_next     = cnt_reg;
      done_next    = done_reg;
      period_next  = period_reg;
      stuck_next   = stuck_reg;
      timeout_next = timeout_reg;

      // Abort paths: explicit clear, or a width change invalidating the running measurement.
      if (clear || (mode_chg && state_reg != IDLE)) begin
         state_next   = IDLE;
         cnt_next     = '0;
         done_next    = 1'b0;
         period_next  = '0;
         stuck_next   = 1'b0;
         timeout_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (en) begin
                  ref_next   = sample;
                  cnt_next   = '0;
                  state_next = ARMED;
               end
            end
            ARMED: begin
               if (en) begin
                  if (sample == ref_reg) begin
                     period_next = cnt_inc;
                     done_next   = 1'b1;
                     stuck_next  = (cnt_inc == CNT_W'(1));
                     state_next  = DONE;
                  end else if (cnt_inc == MAX_C) begin
                     timeout_next = 1'b1;
                     done_next    = 1'b1;
                     period_next  = '0;
                     state_next   = DONE;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign busy    = (state_reg == ARMED);
   assign done    = done_reg;
   assign period  = period_reg;
   assign stuck   = stuck_reg;
   assign timeout = timeout_reg;

endmodule

// File: tb/tb_seq_period_meter.sv
// Bench for seq_period_meter: fixed vector table, counter-source measurements,
// pause / mode-change / reset / timeout sequences and a randomized run against a queue model.
module tb_seq_period_meter;

   localparam int WIDTH = 11;
   localparam int CNT_W = 12;
   localparam int MAX_COUNT = 4095;
   localparam int TO_MAX = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic             en = 1'b0;
   logic             clear = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [WIDTH-1:0] seq_in = '0;
   logic             busy, done, stuck, timeout;
   logic [CNT_W-1:0] period;

   logic             to_en = 1'b0;
   logic             to_clear = 1'b0;
   logic [1:0]       to_mode = 2'd3;
   logic [WIDTH-1:0] to_seq = '0;
   logic             to_busy, to_done, to_stuck, to_timeout;
   logic [CNT_W-1:0] to_period;

   always #5 clk = ~clk;

   seq_period_meter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_COUNT(MAX_COUNT)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode), .seq_in(seq_in),
      .busy(busy), .done(done), .period(period), .stuck(stuck), .timeout(timeout)
   );

   seq_period_meter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_COUNT(TO_MAX)) u_to (
      .clk(clk), .rst_n(rst_n), .en(to_en), .clear(to_clear), .mode(to_mode), .seq_in(to_seq),
      .busy(to_busy), .done(to_done), .period(to_period), .stuck(to_stuck), .timeout(to_timeout)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model: history of masked enabled samples since capture.
   localparam int P_IDLE = 0, P_ARMED = 1, P_DONE = 2;
   int m_phase = P_IDLE;
   int m_hist[$];
   int m_mode_q = 0;
   int e_period = 0;
   bit e_done = 0, e_stuck = 0, e_timeout = 0;

   function automatic void model_clear();
      m_phase = P_IDLE;
      m_hist.delete();
      e_period = 0; e_done = 0; e_stuck = 0; e_timeout = 0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_mode_q = 0;
   endfunction

   function automatic void model_step(input logic e, input logic c, input logic [1:0] m,
                                      input logic [WIDTH-1:0] s);
      int mk;
      mk = int'(s) & ((1 << (8 + int'(m))) - 1);
      if (c) model_clear();
      else if (int'(m) != m_mode_q && m_phase != P_IDLE) model_clear();
      else if (e) begin
         if (m_phase == P_IDLE) begin
            m_hist.push_back(mk);
            m_phase = P_ARMED;
         end else if (m_phase == P_ARMED) begin
            m_hist.push_back(mk);
            if (mk == m_hist[0]) begin
               e_period = m_hist.size() - 1;
               e_done = 1;
               e_stuck = (e_period == 1);
               m_phase = P_DONE;
            end else if (m_hist.size() - 1 == MAX_COUNT) begin
               e_timeout = 1; e_done = 1; e_period = 0;
               m_phase = P_DONE;
            end
         end
      end
      m_mode_q = int'(m);
   endfunction

   task automatic cyc(input logic e, input logic c, input logic [1:0] m, input logic [WIDTH-1:0] s);
      en = e; clear = c; mode = m; seq_in = s;
      model_step(e, c, m, s);
      @(posedge clk);
      #1;
      check("model_busy", busy, (m_phase == P_ARMED));
      check("model_done", done, e_done);
      check("model_period", period, e_period);
      check("model_stuck", stuck, e_stuck);
      check("model_timeout", timeout, e_timeout);
   endtask

   typedef struct {
      logic             en;
      logic             clr;
      logic [1:0]       mode;
      logic [WIDTH-1:0] seq;
      logic             busy;
      logic             done;
      int               period;
      logic             stuck;
      logic             timeout;
   } vec_t;
   vec_t tbl[14];

   // Counter source with optional generator pause; returns after done or budget.
   task automatic measure(input logic [1:0] md, input int pause_at, input int pause_len,
                          input int exp_p, input int exp_busy);
      int c, nbusy, samples, cycles;
      c = 0; nbusy = 0; samples = 0; cycles = 0;
      cyc(1'b0, 1'b1, md, '0);
      while (!done && cycles < 6000) begin
         if (samples == pause_at) begin
            for (int p = 0; p < pause_len; p++) begin
               cyc(1'b0, 1'b0, md, WIDTH'($urandom));
               if (busy) nbusy++;
               cycles++;
            end
         end
         cyc(1'b1, 1'b0, md, WIDTH'(c));
         c = (c + 1) % 2048;
         samples++;
         cycles++;
         if (busy) nbusy++;
      end
      check("cnt_period", period, exp_p);
      check("cnt_done", done, 1);
      check("cnt_stuck", stuck, 0);
      check("cnt_timeout", timeout, 0);
      check("cnt_busy_cycles", nbusy, exp_busy);
      $display("counter mode=%0d pause=%0d: period=%0d busy_cycles=%0d", md, pause_len, period, nbusy);
   endtask

   initial begin
      int c, prev_done, nmeas;
      logic [1:0] rmode;

      tbl[0]  = '{1'b0, 1'b0, 2'd0, 11'h05A, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 2'd0, 11'h05A, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 2'd0, 11'h05A, 1'b0, 1'b1, 1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 2'd0, 11'h123, 1'b0, 1'b1, 1, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 2'd0, 11'h123, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 2'd0, 11'h1AB, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 2'd0, 11'h7CD, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 2'd0, 11'h0AB, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 2'd0, 11'h2AB, 1'b0, 1'b1, 2, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 2'd1, 11'h000, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 2'd1, 11'h1AB, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 2'd1, 11'h0AB, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 2'd1, 11'h3AB, 1'b0, 1'b1, 2, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 2'd1, 11'h000, 1'b0, 1'b0, 0, 1'b0, 1'b0};

      model_reset();
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_period", period, 0);
      check("rst_stuck", stuck, 0);
      check("rst_timeout", timeout, 0);
      #10 rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         cyc(tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].seq);
         check("vec_busy", busy, tbl[i].busy);
         check("vec_done", done, tbl[i].done);
         check("vec_period", period, tbl[i].period);
         check("vec_stuck", stuck, tbl[i].stuck);
         check("vec_timeout", timeout, tbl[i].timeout);
         $display("vector %0d: en=%0b clr=%0b mode=%0d seq=%03h -> busy=%0b done=%0b period=%0d stuck=%0b timeout=%0b",
                  i, tbl[i].en, tbl[i].clr, tbl[i].mode, tbl[i].seq, busy, done, period, stuck, timeout);
      end

      measure(2'd0, -1, 0, 256, 256);
      measure(2'd1, -1, 0, 512, 512);
      measure(2'd2, -1, 0, 1024, 1024);
      measure(2'd3, -1, 0, 2048, 2048);
      measure(2'd0, 50, 20, 256, 276);

      // Mode change 00 -> 01 at sample 100, then re-arm under the 9-bit mask.
      cyc(1'b0, 1'b1, 2'd0, '0);
      c = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1'b1, 1'b0, 2'd0, WIDTH'(c));
         c = (c + 1) % 2048;
      end
      check("mchg_busy_before", busy, 1);
      cyc(1'b1, 1'b0, 2'd1, WIDTH'(c));
      c = (c + 1) % 2048;
      check("mchg_busy", busy, 0);
      check("mchg_done", done, 0);
      check("mchg_period", period, 0);
      for (int i = 0; i < 700 && !done; i++) begin
         cyc(1'b1, 1'b0, 2'd1, WIDTH'(c));
         c = (c + 1) % 2048;
      end
      check("mchg_rearm_period", period, 512);
      check("mchg_rearm_done", done, 1);
      $display("mode change at sample 100: re-armed period=%0d", period);

      // Asynchronous reset in the middle of a measurement.
      cyc(1'b0, 1'b1, 2'd0, '0);
      for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 2'd0, WIDTH'(i));
      check("areset_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("areset_busy", busy, 0);
      check("areset_done", done, 0);
      check("areset_period", period, 0);
      check("areset_stuck", stuck, 0);
      check("areset_timeout", timeout, 0);
      #1 rst_n = 1'b1;
      cyc(1'b0, 1'b0, 2'd0, '0);
      check("areset_idle", busy, 0);
      cyc(1'b1, 1'b0, 2'd0, 11'h011);
      check("areset_rearm", busy, 1);
      $display("async reset mid-measurement: outputs cleared, re-armed busy=%0b", busy);

      // Timeout on the MAX_COUNT=1000 instance with an 11-bit incrementing source.
      to_clear = 1'b1;
      cyc(1'b0, 1'b1, 2'd0, '0);
      to_clear = 1'b0;
      for (int i = 0; i <= TO_MAX; i++) begin
         to_en = 1'b1;
         to_seq = WIDTH'(i);
         cyc(1'b0, 1'b0, 2'd0, '0);
         if (i == TO_MAX - 1) begin
            check("to_done_early", to_done, 0);
            check("to_busy_early", to_busy, 1);
         end
      end
      to_en = 1'b0;
      check("to_done", to_done, 1);
      check("to_timeout", to_timeout, 1);
      check("to_period", to_period, 0);
      check("to_busy", to_busy, 0);
      check("to_stuck", to_stuck, 0);
      $display("timeout run MAX_COUNT=%0d: done=%0b timeout=%0b period=%0d", TO_MAX, to_done, to_timeout, to_period);

      // Randomized run: small alphabet in the low bits, random upper bits, pauses, clears, mode flips.
      rmode = 2'd0;
      prev_done = 0;
      nmeas = 0;
      for (int i = 0; i < 3000; i++) begin
         logic re, rc;
         logic [WIDTH-1:0] rs;
         re = ($urandom_range(0, 9) < 7);
         rc = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 99) == 0) rmode = 2'($urandom);
         rs = {3'($urandom), 6'd0, 2'($urandom_range(0, 3))};
         cyc(re, rc, rmode, rs);
         if (e_done && !prev_done) begin
            nmeas++;
            $display("random measurement %0d: mode=%0d period=%0d stuck=%0b dut_period=%0d",
                     nmeas, rmode, e_period, e_stuck, period);
         end
         prev_done = e_done;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
